// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared types and helpers for the mxv datapath.
//   data_hex_t   : 5-bit decoded hex value (0..15) or HEX_EOL token.
//   uart_state_e : UART receiver FSM states.
//   hex_dec_t    : result of decode_hex (valid flag + value).
//   decode_hex() : maps an ASCII byte to a hex digit or the end-of-entry token.
// -----------------------------------------------------------------------------
package mxv_pkg;

  typedef logic [4:0] data_hex_t;

  localparam data_hex_t HEX_EOL = 5'd30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef struct packed {
    logic      valid;
    data_hex_t value;
  } hex_dec_t;

  // '0'-'9', 'A'-'F', 'a'-'f' map to 0..15; CR maps to HEX_EOL; anything
  // else is reported as not valid.
  function automatic hex_dec_t decode_hex(input logic [7:0] b);
    hex_dec_t r;
    r.valid = 1'b1;
    r.value = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r.value = 5'(b - 8'h30);
    end else if (b >= 8'h41 && b <= 8'h46) begin
      r.value = 5'(b - 8'h37);
    end else if (b >= 8'h61 && b <= 8'h66) begin
      r.value = 5'(b - 8'h57);
    end else if (b == 8'h0D) begin
      r.value = HEX_EOL;
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver: 2-flop synchronizer, start-edge detector, bit FSM.
// Ports:
//   clk         in  : clock, rising edge
//   rst         in  : synchronous active-high reset
//   rx          in  : asynchronous serial line, idle high
//   byte_o      out : last received byte (valid with byte_vld_o)
//   byte_vld_o  out : one-cycle strobe, frame received with good stop bit
//   frame_err_o out : one-cycle strobe, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx_core
  import mxv_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CPB / 2 - 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_core: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic          rx_meta_r;
  logic          rx_s;
  logic          rx_prev_r;
  uart_state_e   state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;

  // Synchronizer plus one extra flop of history for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
      rx_prev_r <= rx_s;
    end
  end

  // Receive FSM with baud/bit counters and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      baud_r      <= BAUD_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'd0;
      byte_o      <= 8'd0;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_r <= BAUD_ZERO;
          bit_r  <= 3'd0;
          // Only a true 1->0 edge starts a frame; a static low line does not.
          if (rx_prev_r && !rx_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (baud_r == HALF_LAST) begin
            baud_r <= BAUD_ZERO;
            // Line back high at mid start bit means a glitch, not a frame.
            if (!rx_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_r == FULL_LAST) begin
            baud_r  <= BAUD_ZERO;
            shift_r <= {rx_s, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              bit_r   <= 3'd0;
              state_r <= STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_r == FULL_LAST) begin
            baud_r  <= BAUD_ZERO;
            state_r <= IDLE;
            if (rx_s) begin
              byte_o     <= shift_r;
              byte_vld_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= BAUD_ZERO;
          bit_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_rx.sv
// -----------------------------------------------------------------------------
// uart_hex_rx
// UART front end of the mxv datapath: receives 8N1 bytes and classifies each
// as a hex digit or the end-of-entry token (CR).
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-high reset
//   rx    in  : asynchronous serial line, idle high
//   hex   out : decoded value, holds between strobes, 0 after reset
//   ena_o out : one-cycle strobe, hex is valid
//   err_o out : one-cycle strobe, framing error or unmapped character
// -----------------------------------------------------------------------------
module uart_hex_rx
  import mxv_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  output data_hex_t hex,
  output logic      ena_o,
  output logic      err_o
);

  logic [7:0] byte_s;
  logic       byte_vld_s;
  logic       frame_err_s;
  hex_dec_t   dec_s;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .byte_o      (byte_s),
    .byte_vld_o  (byte_vld_s),
    .frame_err_o (frame_err_s)
  );

  assign dec_s = decode_hex(byte_s);

  // Output register: strobes last one cycle, hex holds the last valid value.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex   <= 5'd0;
      ena_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ena_o <= 1'b0;
      err_o <= 1'b0;
      if (byte_vld_s) begin
        if (dec_s.valid) begin
          ena_o <= 1'b1;
          hex   <= dec_s.value;
        end else begin
          err_o <= 1'b1;
        end
      end else if (frame_err_s) begin
        err_o <= 1'b1;
      end else begin
        hex <= hex;
      end
    end
  end

endmodule
